mmcm_drp_ctrl: RTL
==================

// Module: mmcm_drp_ctrl
// PURPOSE
//  Sequences the MMCME2_ADV in the clock generator: power-up reset/lock, then runtime
//  reconfiguration through the DRP port. Applies a loaded table of read-modify-write
//  register updates while holding the MMCM in reset, releases reset, waits for LOCKED.
//  Sits in the free-running input-clock domain, between top-level control and the MMCM.
// PARAMETERS
//  N_REGS        8      DRP write-table depth (entries)
//  RST_HOLD      16     cycles o_mmcm_rst held high before release (>=1)
//  DRDY_TIMEOUT  63     max cycles waiting for i_drdy per access
//  LOCK_TIMEOUT  65535  max cycles waiting for i_locked after release
// PORTS
//  i_clk        in   1    free-running input clock (also DCLK)
//  i_rst_n      in   1    asynchronous active-low reset
//  i_tbl_we     in   1    table write strobe (ignored while o_busy)
//  i_tbl_idx    in   $clog2(N_REGS)  table entry index
//  i_tbl_addr   in   7    DRP address for entry
//  i_tbl_mask   in   16   bits=1 keep current value, bits=0 take i_tbl_data
//  i_tbl_data   in   16   new data for entry
//  i_num_regs   in   $clog2(N_REGS+1)  entries to apply, sampled on i_start
//  i_start      in   1    one-cycle request to reconfigure (ignored while o_busy)
//  o_busy       out  1    sequence in progress
//  o_done       out  1    one-cycle pulse: relock achieved
//  o_err        out  1    sticky: DRDY or lock timeout; cleared by next accepted i_start
//  o_locked     out  1    qualified lock: high only in IDLE with i_locked high
//  o_mmcm_rst   out  1    MMCM RST
//  o_daddr      out  7    DRP address
//  o_den        out  1    DRP enable, one-cycle pulse
//  o_dwe        out  1    DRP write enable, qualifies o_den
//  o_di         out  16   DRP write data
//  i_do         in   16   DRP read data
//  i_drdy       in   1    DRP ready
//  i_locked     in   1    MMCM LOCKED
// BEHAVIOUR
//  Reset values: o_mmcm_rst=1, o_busy=1, o_done=0, o_err=0, o_locked=0, o_den=0, o_dwe=0,
//   o_daddr=0, o_di=0; table entries=0; state=HOLD with hold counter=0.
//  States: IDLE, HOLD, RD, RD_WAIT, WR, WR_WAIT, RELEASE, WAIT_LOCK.
//  HOLD: o_mmcm_rst=1; after RST_HOLD cycles -> RD if entries remain, else RELEASE.
//  IDLE + i_start: latch i_num_regs, clear o_err, entry ptr=0, o_busy=1 next cycle -> HOLD.
//  RD: one-cycle o_den=1, o_dwe=0, o_daddr=tbl[ptr].addr -> RD_WAIT.
//  RD_WAIT: on i_drdy, compute (i_do & mask) | (data & ~mask) into o_di -> WR.
//  WR: one-cycle o_den=1, o_dwe=1, same addr -> WR_WAIT.
//  WR_WAIT: on i_drdy, ptr++; ptr==num -> RELEASE, else -> RD.
//  RELEASE: o_mmcm_rst=0, reset lock counter -> WAIT_LOCK.
//  WAIT_LOCK: i_locked high -> IDLE, o_done pulse, o_busy=0 the same cycle.
//  Timeouts: DRDY_TIMEOUT cycles in RD_WAIT/WR_WAIT or LOCK_TIMEOUT cycles in WAIT_LOCK ->
//   o_err=1, go to HOLD (remaining entries abandoned, MMCM re-reset, no further DRP).
//  Lock loss in IDLE (i_locked falls): o_locked=0 same cycle, restart HOLD with no
//   DRP entries; o_err unaffected; o_done pulses on relock.
//  i_num_regs=0 or >N_REGS clipped to N_REGS: 0 gives plain reset-and-relock.
//  i_start and i_tbl_we same cycle in IDLE: table write occurs, start uses new entry.
//  i_drdy outside *_WAIT ignored. At most one DRP access outstanding.
//  o_locked registered: 1 cycle after IDLE entry with i_locked high.
//  Reset asserted mid-sequence: all state returns to reset values immediately.
// TESTING
//  Power-up: release i_rst_n, i_locked rises 40 cycles later -> o_mmcm_rst low after 16
//   cycles, o_done pulse, o_locked=1, no o_den.
//  2-entry reconfig: addr 0x08 mask 0x1000 data 0x0145, addr 0x14 mask 0x1000 data
//   0x03CF, i_do returns 0xFFFF -> writes 0x1145 then 0x13CF, 4 o_den pulses, relock.
//  DRP stall: i_drdy never returns on first read -> o_err=1 after 63 cycles, HOLD, relock.
//  No relock: i_locked held low -> o_err after 65535 cycles in WAIT_LOCK, new HOLD.
//  Lock loss in IDLE: drop i_locked 1 cycle -> o_locked=0, o_mmcm_rst high 16 cycles.
//  i_start while busy, and i_rst_n low in WR_WAIT -> start ignored; outputs at reset values.

Source files
------------

// File: rtl/mmcm_drp_ctrl_if.sv
// Signal bundle between top-level control, the MMCM DRP sequencer and the MMCM itself.
// master = controlling side / MMCM model, slave = the sequencer.
interface mmcm_drp_ctrl_if #(
  parameter int N_REGS = 8
);
  localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int NUM_W = $clog2(N_REGS + 1);

  logic             tbl_we;
  logic [IDX_W-1:0] tbl_idx;
  logic [6:0]       tbl_addr;
  logic [15:0]      tbl_mask;
  logic [15:0]      tbl_data;
  logic [NUM_W-1:0] num_regs;
  logic             start;
  logic             busy;
  logic             done;
  logic             err;
  logic             locked;
  logic             mmcm_rst;
  logic             mmcm_locked;
  logic [6:0]       daddr;
  logic             den;
  logic             dwe;
  logic [15:0]      di;
  logic [15:0]      drp_do;
  logic             drdy;

  modport master (
    output tbl_we, tbl_idx, tbl_addr, tbl_mask, tbl_data, num_regs, start,
    output drp_do, drdy, mmcm_locked,
    input  busy, done, err, locked, mmcm_rst, daddr, den, dwe, di
  );

  modport slave (
    input  tbl_we, tbl_idx, tbl_addr, tbl_mask, tbl_data, num_regs, start,
    input  drp_do, drdy, mmcm_locked,
    output busy, done, err, locked, mmcm_rst, daddr, den, dwe, di
  );
endinterface

// File: rtl/mmcm_drp_ctrl.sv
// MMCM power-up and DRP reconfiguration sequencer: holds the MMCM in reset while
// applying a table of read-modify-write DRP updates, then releases it and waits for lock.
//
// state     | meaning
// IDLE      | locked and quiescent; accepts start and table writes
// HOLD      | MMCM held in reset for RST_HOLD cycles
// RD        | one-cycle DRP read strobe for current entry
// RD_WAIT   | waiting for read DRDY
// WR        | one-cycle DRP write strobe with merged data
// WR_WAIT   | waiting for write DRDY
// RELEASE   | MMCM reset deasserted
// WAIT_LOCK | waiting for LOCKED
module mmcm_drp_ctrl #(
  parameter int N_REGS       = 8,
  parameter int RST_HOLD     = 16,
  parameter int DRDY_TIMEOUT = 63,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic           clk,
  input  logic           rst_n,
  mmcm_drp_ctrl_if.slave bus
);
  localparam int IDX_W   = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int NUM_W   = $clog2(N_REGS + 1);
  localparam int TMR_MX1 = (RST_HOLD > DRDY_TIMEOUT) ? RST_HOLD : DRDY_TIMEOUT;
  localparam int TMR_MAX = (TMR_MX1 > LOCK_TIMEOUT) ? TMR_MX1 : LOCK_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HOLD_TC = TMR_W'(RST_HOLD - 1);
  localparam logic [TMR_W-1:0] DRDY_TC = TMR_W'(DRDY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LOCK_TC = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [NUM_W-1:0] NUM_MAX = NUM_W'(N_REGS);

  typedef enum logic [2:0] {
    IDLE, HOLD, RD, RD_WAIT, WR, WR_WAIT, RELEASE, WAIT_LOCK
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [NUM_W-1:0] ptr, ptr_nxt;
  logic [NUM_W-1:0] num, num_nxt;
  logic [NUM_W-1:0] num_clip;
  logic [IDX_W-1:0] cur_idx, nxt_idx;
  logic             err_set, err_clr;
  logic [15:0]      rmw;

  logic [6:0]       tbl_addr [N_REGS];
  logic [15:0]      tbl_mask [N_REGS];
  logic [15:0]      tbl_data [N_REGS];

  logic             mmcm_rst_q, busy_q, done_q, err_q, locked_q, den_q, dwe_q;
  logic [6:0]       daddr_q;
  logic [15:0]      di_q;

  assign cur_idx  = ptr[IDX_W-1:0];
  assign nxt_idx  = ptr_nxt[IDX_W-1:0];
  assign num_clip = (bus.num_regs > NUM_MAX) ? NUM_MAX : bus.num_regs;
  // mask bit 1 keeps the MMCM's current bit, 0 takes the table bit
  assign rmw      = (bus.drp_do & tbl_mask[cur_idx]) | (tbl_data[cur_idx] & ~tbl_mask[cur_idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++) begin
        tbl_addr[i] <= '0;
        tbl_mask[i] <= '0;
        tbl_data[i] <= '0;
      end
    end else if (bus.tbl_we && state == IDLE) begin
      tbl_addr[bus.tbl_idx] <= bus.tbl_addr;
      tbl_mask[bus.tbl_idx] <= bus.tbl_mask;
      tbl_data[bus.tbl_idx] <= bus.tbl_data;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    num_nxt   = num;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = HOLD;
          num_nxt   = num_clip;
          ptr_nxt   = '0;
          err_clr   = 1'b1;
        end else if (!bus.mmcm_locked) begin
          state_nxt = HOLD;
          num_nxt   = '0;
          ptr_nxt   = '0;
        end
      end
      HOLD: if (tmr == HOLD_TC) state_nxt = (ptr < num) ? RD : RELEASE;
      RD:   state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (bus.drdy) begin
          state_nxt = WR;
        end else if (tmr == DRDY_TC) begin
          state_nxt = HOLD;
          err_set   = 1'b1;
          num_nxt   = '0;
          ptr_nxt   = '0;
        end
      end
      WR:   state_nxt = WR_WAIT;
      WR_WAIT: begin
        if (bus.drdy) begin
          ptr_nxt   = ptr + 1'b1;
          state_nxt = (ptr_nxt == num) ? RELEASE : RD;
        end else if (tmr == DRDY_TC) begin
          state_nxt = HOLD;
          err_set   = 1'b1;
          num_nxt   = '0;
          ptr_nxt   = '0;
        end
      end
      RELEASE: state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (bus.mmcm_locked) begin
          state_nxt = IDLE;
        end else if (tmr == LOCK_TC) begin
          state_nxt = HOLD;
          err_set   = 1'b1;
          num_nxt   = '0;
          ptr_nxt   = '0;
        end
      end
      default: state_nxt = HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HOLD;
      tmr        <= '0;
      ptr        <= '0;
      num        <= '0;
      mmcm_rst_q <= 1'b1;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      daddr_q    <= '0;
      di_q       <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      num   <= num_nxt;
      if (state_nxt != state) tmr <= '0;
      else if (state != IDLE) tmr <= tmr + 1'b1;
      mmcm_rst_q <= (state_nxt == HOLD) || (state_nxt == RD) || (state_nxt == RD_WAIT) ||
                    (state_nxt == WR) || (state_nxt == WR_WAIT);
      busy_q     <= (state_nxt != IDLE);
      done_q     <= (state == WAIT_LOCK) && (state_nxt == IDLE);
      if (err_set) err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
      locked_q   <= (state == IDLE) && (state_nxt == IDLE) && bus.mmcm_locked;
      den_q      <= (state_nxt == RD) || (state_nxt == WR);
      dwe_q      <= (state_nxt == WR);
      if (state_nxt == RD) daddr_q <= tbl_addr[nxt_idx];
      if (state == RD_WAIT && bus.drdy) di_q <= rmw;
    end
  end

  assign bus.mmcm_rst = mmcm_rst_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  // gated with the raw LOCKED so a lock loss shows up in the same cycle
  assign bus.locked   = locked_q & bus.mmcm_locked;
  assign bus.den      = den_q;
  assign bus.dwe      = dwe_q;
  assign bus.daddr    = daddr_q;
  assign bus.di       = di_q;
endmodule
